pwm_gen: RTL and testbench
==========================

# pwm_gen

Multi-channel PWM generator that consumes the duty values produced by the fade controller and drives the LED pins. A free-running period counter compares against per-channel duty registers. New duty words are accepted through a valid/ready handshake and applied only at a period boundary, so no glitched or partial periods appear on the outputs.

## Interface
- `PWM_INTERVAL`, 1200: period length in `clk` cycles (100 us at 12 MHz).
- `NUM_CH`, 3: number of PWM channels (R, G, B).
- `W`, `$clog2(PWM_INTERVAL)`: duty input width per channel.
- `clk`  in  1  system clock, 12 MHz.
- `rst`  in  1  reset; asynchronous, active-high.
- `duty_in`  in  `NUM_CH*W`  packed duty words; channel i occupies bits [i*W +: W].
- `duty_valid`  in  1  `duty_in` holds a new set of duties.
- `duty_ready`  out  1  block can accept a new set this cycle.
- `pwm_out`  out  `NUM_CH`  registered PWM outputs.
- `period_start`  out  1  one-cycle pulse on the first cycle of each period.

## Operation
- Period counter `count` runs 0..`PWM_INTERVAL`-1 and wraps to 0. Increments every cycle.
- Each channel has a shadow register and an active duty register, both of width `$clog2(PWM_INTERVAL+1)`.
- `duty_ready` = !`pending`.
- Handshake fires when `duty_valid && duty_ready`:
  - all channels are captured into the shadow registers;
  - `pending` is set to 1;
  - each value is clamped to `PWM_INTERVAL` at capture.
- On the wrap cycle (`count == PWM_INTERVAL-1`) with `pending` = 1: shadow is copied to active for all channels together, and `pending` is cleared.
- Per channel: `pwm_out[i]` <= (`count` < `active[i]`).
- Duty boundary cases:
  - duty 0: output never high;
  - duty ≥ `PWM_INTERVAL`: output high for the whole period, with no low cycle.
- Holding `duty_valid` high while not ready has no effect. Data is sampled only on the handshake cycle.

## Timing
- Reset values:
  - `count` = 0, active = 0, shadow = 0, `pending` = 0;
  - `duty_ready` = 1, `pwm_out` = 0 (all-ones with the config macro), `period_start` = 0.
- The first `clk` edge after `rst` deasserts evaluates `count` = 0.
- `period_start` is registered and high on the cycle where `pwm_out` reflects `count` = 0.
- Latency:
  - `pwm_out` lags `count` by 1 cycle;
  - duty D yields exactly D consecutive high cycles per period, starting with the `period_start` cycle.
- Handshake on a non-wrap cycle: the new duty takes effect on the next wrap.
- Handshake on the wrap cycle itself: it requires `pending` = 0, so nothing is applied that cycle. The data is applied at the following wrap, with no bypass into the current period.
- Update rate: at most one update per period. The fade source (1 ms step) never back-pressures in normal use.
- Reset mid-period: all state is cleared immediately (async) and outputs go to their reset values. A pending update is discarded.

## Configuration
- `PWM_ACTIVE_LOW_EN` defined:
  - every `pwm_out` bit is inverted at the output register, for common-anode LED pins;
  - reset value is all-ones.
- Not defined: active-high outputs, reset value all-zeros.
- `period_start`, handshake behaviour and timing are identical in both builds.

## Structure
- Package `pwm_pkg`:
  - default `PWM_INTERVAL`, `NUM_CH`;
  - `localparam` widths (`W`, active width);
  - channel-index constants `CH_R`, `CH_G`, `CH_B`.
- Sub-module `pwm_channel`, instantiated `NUM_CH` times via generate:
  - contents: shadow register, active register, clamp, compare and output register;
  - shared inputs from the top: `count`, the capture strobe and the apply strobe.
- Top level holds `count`, `pending`, the handshake and `period_start`.

## Test plan
- Reset, then no handshake:
  - `pwm_out` = 0 on all channels for 3 periods;
  - `period_start` pulses every 1200 cycles;
  - `duty_ready` = 1.
- Load duties 600/0/1199 mid-period:
  - `duty_ready` drops next cycle;
  - at the next `period_start`: ch0 high exactly 600 cycles, ch1 never high, ch2 high 1199 cycles;
  - `duty_ready` returns to 1 after the wrap.
- Load duty 2047 on ch0 → clamped; ch0 high for all 1200 cycles, with no low cycle across two consecutive periods.
- Handshake on the exact wrap cycle, then a second `duty_valid` held high:
  - first set applied one full period later;
  - second set accepted only after `duty_ready` reasserts.
- Assert `rst` at `count` = 500 with a pending update:
  - outputs go to their reset values asynchronously;
  - after release, the pending data is never applied.
- With `PWM_ACTIVE_LOW_EN`: repeat the 600-duty case and check an inverted waveform with reset value all-ones.

Source files
------------

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Shared definitions for the multi-channel PWM generator (pwm_gen).
//
//   Contents:
//     PWM_INTERVAL_DEF / NUM_CH_DEF  default period length and channel count
//     W_DEF / AW_DEF                 duty input width and active-register width
//     CH_R / CH_G / CH_B             channel index of each LED colour
//     upd_state_e                    duty-update handshake state
//     PWM_IDLE_LEVEL                 output level while a channel is "off"
//     active_width()                 width able to hold 0..interval inclusive
//
//   Configuration macro:
//     PWM_ACTIVE_LOW_EN  defined  -> outputs inverted (common-anode LEDs),
//                                    reset level all-ones
//                        undefined -> active-high outputs, reset level all-zeros
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int unsigned PWM_INTERVAL_DEF = 1200;
    localparam int unsigned NUM_CH_DEF       = 3;

    localparam int unsigned W_DEF  = $clog2(PWM_INTERVAL_DEF);
    localparam int unsigned AW_DEF = $clog2(PWM_INTERVAL_DEF + 1);

    localparam int unsigned CH_R = 0;
    localparam int unsigned CH_G = 1;
    localparam int unsigned CH_B = 2;

    // IDLE: no update waiting, a new duty set may be accepted.
    // PENDING: a captured set waits in the shadow registers for the next wrap.
    typedef enum logic {
        UPD_IDLE    = 1'b0,
        UPD_PENDING = 1'b1
    } upd_state_e;

`ifdef PWM_ACTIVE_LOW_EN
    localparam logic PWM_IDLE_LEVEL = 1'b1;
`else
    localparam logic PWM_IDLE_LEVEL = 1'b0;
`endif

    // The active register must represent the full-on value (== interval),
    // which can need one more bit than the period counter.
    function automatic int unsigned active_width(input int unsigned interval);
        return $clog2(interval + 1);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// -----------------------------------------------------------------------------
// pwm_channel
//   One PWM channel: clamps and captures a duty word into a shadow register,
//   transfers it to the active register on the apply strobe, and drives a
//   registered output that is "on" while count_i < active.
//
//   Ports:
//     clk        in   system clock
//     rst        in   asynchronous active-high reset
//     duty_i     in   [W-1:0]  raw duty word for this channel
//     count_i    in   [AW-1:0] shared period counter
//     capture_i  in   load clamped duty_i into the shadow register
//     apply_i    in   copy shadow into active (period boundary)
//     pwm_o      out  registered PWM output
//
//   Configuration macro (via pwm_pkg): PWM_ACTIVE_LOW_EN inverts pwm_o and
//   makes its reset value 1.
// -----------------------------------------------------------------------------
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned PWM_INTERVAL = PWM_INTERVAL_DEF,
    parameter int unsigned W            = $clog2(PWM_INTERVAL),
    parameter int unsigned AW           = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  duty_i,
    input  logic [AW-1:0] count_i,
    input  logic          capture_i,
    input  logic          apply_i,
    output logic          pwm_o
);

    logic [AW-1:0] shadow_q;
    logic [AW-1:0] shadow_d;
    logic [AW-1:0] active_q;
    logic [AW-1:0] active_d;
    logic          pwm_q;
    logic          pwm_d;
    logic [AW-1:0] duty_clamped;

    // Anything at or above the interval means "on for the whole period";
    // storing exactly PWM_INTERVAL keeps count_i < active true for every count.
    always_comb begin
        if (32'(duty_i) >= PWM_INTERVAL) begin
            duty_clamped = AW'(PWM_INTERVAL);
        end else begin
            duty_clamped = AW'(duty_i);
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (capture_i) begin
            shadow_d = duty_clamped;
        end
        if (apply_i) begin
            active_d = shadow_q;
        end
        // Polarity is applied here so the pin itself is a flop output.
        pwm_d = (count_i < active_q) ^ PWM_IDLE_LEVEL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= PWM_IDLE_LEVEL;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
//   Multi-channel PWM generator. A free-running counter (0..PWM_INTERVAL-1)
//   is compared against per-channel active duty registers. New duty sets
//   arrive over a valid/ready handshake, wait in shadow registers and are
//   applied to all channels together on the wrap cycle, so every output
//   period is whole and uses a single duty set.
//
//   Ports:
//     clk           in   system clock (12 MHz)
//     rst           in   asynchronous active-high reset
//     duty_in       in   [NUM_CH*W-1:0] packed duties, channel i at [i*W +: W]
//     duty_valid    in   duty_in holds a new duty set
//     duty_ready    out  a new set can be accepted this cycle
//     pwm_out       out  [NUM_CH-1:0] registered PWM outputs
//     period_start  out  one-cycle pulse on the first cycle of each period
//
//   Configuration macro: PWM_ACTIVE_LOW_EN (see pwm_pkg) inverts pwm_out and
//   sets its reset value to all-ones; everything else is unchanged.
// -----------------------------------------------------------------------------
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int unsigned PWM_INTERVAL = PWM_INTERVAL_DEF,
    parameter int unsigned NUM_CH       = NUM_CH_DEF,
    parameter int unsigned W            = $clog2(PWM_INTERVAL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH*W-1:0]   duty_in,
    input  logic                  duty_valid,
    output logic                  duty_ready,
    output logic [NUM_CH-1:0]     pwm_out,
    output logic                  period_start
);

    localparam int unsigned   AW   = active_width(PWM_INTERVAL);
    localparam logic [AW-1:0] LAST = AW'(PWM_INTERVAL - 1);

    // The counter shares the active-register width so the per-channel
    // compare needs no width adaption.
    logic [AW-1:0] count_q;
    logic [AW-1:0] count_d;
    upd_state_e    state_q;
    upd_state_e    state_d;
    logic          period_start_q;
    logic          period_start_d;

    logic wrap;
    logic capture;
    logic apply;

    assign wrap       = (count_q == LAST);
    assign duty_ready = (state_q == UPD_IDLE);
    assign capture    = duty_valid && duty_ready;
    // capture needs IDLE and apply needs PENDING, so they never coincide:
    // data accepted on the wrap cycle is held until the following wrap.
    assign apply      = wrap && (state_q == UPD_PENDING);

    always_comb begin
        count_d        = wrap ? '0 : count_q + AW'(1);
        // Registered, so it lines up with the pwm_out cycle showing count 0.
        period_start_d = (count_q == '0);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            UPD_IDLE: begin
                if (capture) begin
                    state_d = UPD_PENDING;
                end
            end
            UPD_PENDING: begin
                if (wrap) begin
                    state_d = UPD_IDLE;
                end
            end
            default: state_d = UPD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q        <= '0;
            state_q        <= UPD_IDLE;
            period_start_q <= 1'b0;
        end else begin
            count_q        <= count_d;
            state_q        <= state_d;
            period_start_q <= period_start_d;
        end
    end

    assign period_start = period_start_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(
            .PWM_INTERVAL (PWM_INTERVAL),
            .W            (W),
            .AW           (AW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .duty_i    (duty_in[i*W +: W]),
            .count_i   (count_q),
            .capture_i (capture),
            .apply_i   (apply),
            .pwm_o     (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_gen.sv
module tb_pwm_gen;

    localparam int PER = 1200;
    localparam int W   = 11;
    localparam int NCH = 3;

`ifdef PWM_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NCH*W-1:0]   duty_in = '0;
    logic               duty_valid = 1'b0;
    logic               duty_ready;
    logic [NCH-1:0]     pwm_out;
    logic               period_start;

    int n_cmp  = 0;
    int n_fail = 0;

    pwm_gen #(
        .PWM_INTERVAL (PER),
        .NUM_CH       (NCH),
        .W            (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH*W-1:0] pack(input int d0, input int d1, input int d2);
        return {W'(d2), W'(d1), W'(d0)};
    endfunction

    // Step on falling edges until period_start is seen, bounded by budget.
    task automatic wait_ps(input string tag, input int budget, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (period_start === 1'b1) found = 1'b1;
        end
        check({tag, "_found"}, int'(found), 1);
    endtask

    // Called on the falling edge of a period_start cycle; samples one full
    // period and checks each channel is on for exactly min(d,PER) cycles at
    // the start of the period. Optionally drives a handshake mid-period and
    // checks duty_ready at one sample point.
    task automatic run_period(input int d0, input int d1, input int d2,
                              input int set_k, input logic [NCH*W-1:0] set_duty,
                              input int clr_k, input int rdy_k, input logic rdy_exp,
                              input string tag);
        int d[NCH];
        int on_cnt[NCH];
        int pos_err[NCH];
        int ps_err;
        d[0] = d0; d[1] = d1; d[2] = d2;
        ps_err = 0;
        for (int c = 0; c < NCH; c++) begin
            on_cnt[c]  = 0;
            pos_err[c] = 0;
        end
        for (int k = 0; k < PER; k++) begin
            if (period_start !== (k == 0)) ps_err++;
            for (int c = 0; c < NCH; c++) begin
                logic lvl;
                lvl = pwm_out[c] ^ INV;
                if (lvl === 1'b1) on_cnt[c]++;
                if (lvl !== (k < d[c])) pos_err[c]++;
            end
            if (k == rdy_k) check({tag, "_ready"}, int'(duty_ready), int'(rdy_exp));
            if (k == clr_k) duty_valid = 1'b0;
            if (k == set_k) begin
                duty_in    = set_duty;
                duty_valid = 1'b1;
            end
            @(negedge clk);
        end
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("%s_ch%0d_on", tag, c), on_cnt[c], (d[c] > PER) ? PER : d[c]);
            check($sformatf("%s_ch%0d_shape", tag, c), pos_err[c], 0);
        end
        check({tag, "_period_start"}, ps_err, 0);
    endtask

    initial begin
        int cyc;

        // Reset state, checked while rst is held.
        #1 rst = 1'b1;
        #2;
        check("rst_pwm", int'(pwm_out), INV ? 7 : 0);
        check("rst_ps", int'(period_start), 0);
        check("rst_ready", int'(duty_ready), 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ps("first_ps", 5, cyc);
        check("first_ps_latency", cyc, 1);

        // Idle: no handshake for three periods.
        run_period(0, 0, 0, -1, '0, -1, 0, 1'b1, "idle0");
        run_period(0, 0, 0, -1, '0, -1, 0, 1'b1, "idle1");
        run_period(0, 0, 0, -1, '0, -1, 0, 1'b1, "idle2");

        // Mid-period load of 600/0/1199; ready drops the cycle after.
        run_period(0, 0, 0, 100, pack(600, 0, 1199), 101, 101, 1'b0, "load_mid");
        run_period(600, 0, 1199, -1, '0, -1, 0, 1'b1, "duty_600");

        // Over-range duty on ch0: full-on for two consecutive periods.
        run_period(600, 0, 1199, 300, pack(2047, 0, 0), 301, 301, 1'b0, "load_clamp");
        run_period(2047, 0, 0, -1, '0, -1, 0, 1'b1, "clamp_p0");
        run_period(2047, 0, 0, -1, '0, -1, -1, 1'b0, "clamp_p1");

        // Handshake on the wrap cycle (count 1199): set A must wait a period.
        run_period(2047, 0, 0, 1198, pack(100, 200, 300), 1199, 1199, 1'b0, "wrap_hs");
        // Set B held valid while A pends; ready returns only after the wrap.
        run_period(2047, 0, 0, 10, pack(1, 1200, 1199), -1, 1199, 1'b1, "hold_b");
        run_period(100, 200, 300, -1, '0, 0, 0, 1'b0, "apply_a");
        run_period(1, 1200, 1199, -1, '0, -1, 0, 1'b1, "apply_b");

        // Reset at count 500 with update C pending.
        repeat (10) @(negedge clk);
        duty_in    = pack(900, 900, 900);
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        check("c_ready", int'(duty_ready), 0);
        repeat (488) @(negedge clk);
        check("pre_rst_pwm", int'(pwm_out), INV ? 1 : 6);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_pwm", int'(pwm_out), INV ? 7 : 0);
        check("mid_rst_ps", int'(period_start), 0);
        check("mid_rst_ready", int'(duty_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_ps("post_rst_ps", 5, cyc);
        check("post_rst_latency", cyc, 1);
        run_period(0, 0, 0, -1, '0, -1, 0, 1'b1, "post_rst0");
        run_period(0, 0, 0, -1, '0, -1, 0, 1'b1, "post_rst1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
